transform_param_ctrl: RTL and testbench

- Configuration controller for the perspective-transform pipeline.
- Accepts coefficient and output-size writes from the command decoder into a shadow bank.
- On commit, waits for a camera frame boundary and for the transform pipeline to drain, then swaps the shadow bank into the active outputs atomically.
- Drives the T11..T33, TRA_IMG_WIDTH and TRA_IMG_DEPTH inputs of the transform stage, so no frame is ever processed with mixed coefficients.

---
 rtl/transform_param_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_transform_param_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/transform_param_ctrl.sv
// transform_param_ctrl
//   Configuration controller for the perspective-transform pipeline.
//   The command decoder writes coefficients and the output size into a
//   shadow bank. A commit waits for the next camera frame boundary, lets the
//   transform pipeline drain, then copies the whole shadow bank into the
//   active registers in one cycle. This means no frame is processed with a
//   mix of old and new coefficients.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_valid/ready   write handshake. A transfer happens in any cycle where
//                     cfg_valid & cfg_ready are both high. cfg_ready depends
//                     only on the FSM state, never on cfg_valid.
//   cfg_addr/data     0..8 = T11..T33, 9 = width, 10 = depth
//   cfg_commit        swap request, sampled only while cfg_ready = 1
//   frame_end         one-cycle pulse after the last pixel of a camera frame
//   busy              high whenever the FSM is not in IDLE
//   cfg_err           one-cycle pulse the cycle after a rejected write
//   update_done       one-cycle pulse when new active values first appear
//   T11..T33          active coefficients (signed, 12 fractional bits)
//   img_width/depth   active output image size
//   dbg_state         current FSM state, for observation only
module transform_param_ctrl #(
   parameter int CAM_LINE   = 9,
   parameter int CAM_PIXEL  = 10,
   parameter int COEF_W     = 25,
   parameter int PIPE_DEPTH = 7,
   parameter int DEF_WIDTH  = 160,
   parameter int DEF_DEPTH  = 160
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [3:0]           cfg_addr,
   input  logic [COEF_W-1:0]    cfg_data,
   input  logic                 cfg_commit,
   input  logic                 frame_end,
   output logic                 busy,
   output logic                 cfg_err,
   output logic                 update_done,
   output logic [COEF_W-1:0]    T11,
   output logic [COEF_W-1:0]    T12,
   output logic [COEF_W-1:0]    T13,
   output logic [COEF_W-1:0]    T21,
   output logic [COEF_W-1:0]    T22,
   output logic [COEF_W-1:0]    T23,
   output logic [COEF_W-1:0]    T31,
   output logic [COEF_W-1:0]    T32,
   output logic [COEF_W-1:0]    T33,
   output logic [CAM_PIXEL-1:0] img_width,
   output logic [CAM_LINE-1:0]  img_depth,
   output logic [1:0]           dbg_state
);

   localparam int CNT_W     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam int MAX_WIDTH = 640;
   localparam int MAX_DEPTH = 480;

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, DRAIN, SWAP} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 dirty_q;
   logic                 wr_ok, wr_bad, commit_fire, do_swap, done_d;

   logic [COEF_W-1:0]    sh_coef  [9];
   logic [COEF_W-1:0]    act_coef [9];
   logic [CAM_PIXEL-1:0] sh_width, act_width;
   logic [CAM_LINE-1:0]  sh_depth, act_depth;

   // Identity matrix: the diagonal entries are 1.0 in 12-bit fixed point.
   function automatic logic [COEF_W-1:0] coef_default(input int idx);
      return (idx == 0 || idx == 4 || idx == 8) ? COEF_W'(4096) : '0;
   endfunction

   assign cfg_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign commit_fire = cfg_commit & cfg_ready;
   assign dbg_state   = state_q;

   // Check whether an accepted write targets a valid address with a legal
   // size value. Only the low bits of cfg_data count for width and depth.
   always_comb begin
      wr_ok  = 1'b0;
      wr_bad = 1'b0;
      if (cfg_valid && cfg_ready) begin
         if (cfg_addr <= 4'd8) begin
            wr_ok = 1'b1;
         end else if (cfg_addr == 4'd9) begin
            if ((cfg_data[CAM_PIXEL-1:0] != '0) &&
                (cfg_data[CAM_PIXEL-1:0] <= CAM_PIXEL'(MAX_WIDTH)))
               wr_ok = 1'b1;
            else
               wr_bad = 1'b1;
         end else if (cfg_addr == 4'd10) begin
            if ((cfg_data[CAM_LINE-1:0] != '0) &&
                (cfg_data[CAM_LINE-1:0] <= CAM_LINE'(MAX_DEPTH)))
               wr_ok = 1'b1;
            else
               wr_bad = 1'b1;
         end else begin
            wr_bad = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_swap = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A write in the same cycle as the commit counts toward dirty.
            // This is because the write lands in the shadow bank first.
            if (commit_fire) begin
               if (dirty_q || wr_ok) state_d = WAIT_FRAME;
               else                  done_d  = 1'b1;
            end
         end
         WAIT_FRAME: begin
            if (frame_end) begin
               state_d = DRAIN;
               cnt_d   = CNT_W'(PIPE_DEPTH - 1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = SWAP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         SWAP: begin
            state_d = IDLE;
            do_swap = 1'b1;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dirty_q     <= 1'b0;
         cfg_err     <= 1'b0;
         update_done <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            sh_coef[i]  <= coef_default(i);
            act_coef[i] <= coef_default(i);
         end
         sh_width  <= CAM_PIXEL'(DEF_WIDTH);
         act_width <= CAM_PIXEL'(DEF_WIDTH);
         sh_depth  <= CAM_LINE'(DEF_DEPTH);
         act_depth <= CAM_LINE'(DEF_DEPTH);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cfg_err     <= wr_bad;
         update_done <= done_d;
         if (wr_ok) begin
            dirty_q <= 1'b1;
            for (int i = 0; i < 9; i++)
               if (cfg_addr == 4'(i)) sh_coef[i] <= cfg_data;
            if (cfg_addr == 4'd9)  sh_width <= cfg_data[CAM_PIXEL-1:0];
            if (cfg_addr == 4'd10) sh_depth <= cfg_data[CAM_LINE-1:0];
         end
         // Writes are never accepted in SWAP, so this cannot collide with wr_ok.
         if (do_swap) begin
            dirty_q <= 1'b0;
            for (int i = 0; i < 9; i++) act_coef[i] <= sh_coef[i];
            act_width <= sh_width;
            act_depth <= sh_depth;
         end
      end
   end

   assign T11       = act_coef[0];
   assign T12       = act_coef[1];
   assign T13       = act_coef[2];
   assign T21       = act_coef[3];
   assign T22       = act_coef[4];
   assign T23       = act_coef[5];
   assign T31       = act_coef[6];
   assign T32       = act_coef[7];
   assign T33       = act_coef[8];
   assign img_width = act_width;
   assign img_depth = act_depth;

endmodule

// File: tb/tb_transform_param_ctrl.sv
// Testbench for transform_param_ctrl. Directed scenarios and random traffic
// are compared every cycle against a transaction-level model. The model
// tracks the shadow and active banks and a pending-swap deadline, computed
// as (frame_end cycle + PIPE_DEPTH + 2).
module tb_transform_param_ctrl;
  localparam int PIPE_DEPTH = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = '0;
  logic [24:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        frame_end = 1'b0;
  logic        busy, cfg_err, update_done;
  logic [24:0] t_out [9];
  logic [9:0]  img_width;
  logic [8:0]  img_depth;
  logic [1:0]  dbg_state;

  transform_param_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .frame_end(frame_end), .busy(busy), .cfg_err(cfg_err),
    .update_done(update_done),
    .T11(t_out[0]), .T12(t_out[1]), .T13(t_out[2]),
    .T21(t_out[3]), .T22(t_out[4]), .T23(t_out[5]),
    .T31(t_out[6]), .T32(t_out[7]), .T33(t_out[8]),
    .img_width(img_width), .img_depth(img_depth), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;
  bit chk_en   = 1'b0;

  // reference model state
  logic [24:0] m_sh [9];
  logic [24:0] m_act [9];
  logic [9:0]  m_sh_w, m_act_w;
  logic [8:0]  m_sh_d, m_act_d;
  bit          m_dirty, m_pending, m_armed;
  int          m_swap_at, m_fe_cycle;
  bit          exp_err, exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_sh[i]  = (i == 0 || i == 4 || i == 8) ? 25'h001000 : 25'h0;
      m_act[i] = m_sh[i];
    end
    m_sh_w = 10'd160; m_act_w = 10'd160;
    m_sh_d = 9'd160;  m_act_d = 9'd160;
    m_dirty = 0; m_pending = 0; m_armed = 0;
    m_swap_at = -1; m_fe_cycle = -1;
    exp_err = 0; exp_done = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] a, input logic [24:0] d,
                            input logic cm, input logic fe, input logic r);
    bit rdy, ok;
    int idx;
    if (r) begin
      model_reset();
      return;
    end
    rdy = !m_pending;
    exp_err = 0;
    exp_done = 0;
    if (rdy && v) begin
      ok = 1;
      idx = int'(a);
      if (idx <= 8) m_sh[idx] = d;
      else if (idx == 9) begin
        if (d[9:0] != 0 && d[9:0] <= 10'd640) m_sh_w = d[9:0]; else ok = 0;
      end else if (idx == 10) begin
        if (d[8:0] != 0 && d[8:0] <= 9'd480) m_sh_d = d[8:0]; else ok = 0;
      end else ok = 0;
      if (ok) m_dirty = 1; else exp_err = 1;
    end
    if (rdy && cm) begin
      if (m_dirty) begin m_pending = 1; m_armed = 1; end
      else exp_done = 1;
    end
    if (!rdy && m_armed && fe) begin
      m_armed = 0;
      m_swap_at = cyc_n + PIPE_DEPTH + 2;
      m_fe_cycle = cyc_n;
    end
    if (m_pending && !m_armed && (cyc_n + 1 == m_swap_at)) begin
      for (int i = 0; i < 9; i++) m_act[i] = m_sh[i];
      m_act_w = m_sh_w;
      m_act_d = m_sh_d;
      m_dirty = 0;
      m_pending = 0;
      m_swap_at = -1;
      exp_done = 1;
    end
  endtask

  task automatic check_outputs();
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
    check("busy", 32'(busy), 32'(m_pending));
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    check("update_done", 32'(update_done), 32'(exp_done));
    for (int i = 0; i < 9; i++)
      check($sformatf("T%0d%0d", i / 3 + 1, i % 3 + 1), 32'(t_out[i]), 32'(m_act[i]));
    check("img_width", 32'(img_width), 32'(m_act_w));
    check("img_depth", 32'(img_depth), 32'(m_act_d));
    if (update_done === 1'b1 && m_fe_cycle >= 0) begin
      check("swap_latency", 32'(cyc_n - m_fe_cycle), 32'(PIPE_DEPTH + 2));
      m_fe_cycle = -1;
    end
  endtask

  // driver: one clock cycle of stimulus followed by a mid-cycle check
  task automatic cyc(input logic v, input logic [3:0] a, input logic [24:0] d,
                     input logic cm, input logic fe, input logic r);
    @(posedge clk);
    #1;
    cfg_valid = v; cfg_addr = a; cfg_data = d;
    cfg_commit = cm; frame_end = fe; rst = r;
    @(negedge clk);
    if (chk_en) check_outputs();
    model_step(v, a, d, cm, fe, r);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 25'h0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [24:0] d);
    cyc(1, a, d, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [24:0] d;
    logic [3:0]  a;
    model_reset();
    cyc(0, 4'd0, 25'h0, 0, 0, 1);
    cyc(0, 4'd0, 25'h0, 0, 0, 1);
    chk_en = 1'b1;
    idle(2);
    // reset values against fixed constants
    check("rst_T11", 32'(t_out[0]), 32'h001000);
    check("rst_T13", 32'(t_out[2]), 32'h0);
    check("rst_T33", 32'(t_out[8]), 32'h001000);
    check("rst_width", 32'(img_width), 32'd160);
    check("rst_depth", 32'(img_depth), 32'd160);

    // staged T31 and width, then a commit and a single frame_end
    wr(4'd6, 25'h1E3F3F);
    wr(4'd9, 25'd320);
    cyc(0, 4'd0, 25'h0, 1, 0, 0);
    idle(3);
    cyc(0, 4'd0, 25'h0, 0, 1, 0);
    idle(12);
    check("s2_T31", 32'(t_out[6]), 32'h1E3F3F);
    check("s2_width", 32'(img_width), 32'd320);

    // rejected writes, then a commit with nothing staged
    wr(4'd12, 25'h123);
    wr(4'd10, 25'h0);
    wr(4'd9, 25'd641);
    wr(4'd10, 25'd481);
    cyc(0, 4'd0, 25'h0, 1, 0, 0);
    idle(3);

    // write plus commit in one cycle, then ignored traffic in WAIT_FRAME
    cyc(1, 4'd0, 25'h003000, 1, 0, 0);
    cyc(1, 4'd0, 25'h002000, 1, 0, 0);
    cyc(1, 4'd10, 25'd100, 1, 0, 0);
    cyc(0, 4'd0, 25'h0, 0, 1, 0);
    idle(12);
    check("s4_T11", 32'(t_out[0]), 32'h003000);

    // repeated frame_end pulses while draining
    wr(4'd10, 25'd480);
    cyc(0, 4'd0, 25'h0, 1, 0, 0);
    cyc(0, 4'd0, 25'h0, 0, 1, 0);
    cyc(0, 4'd0, 25'h0, 0, 1, 0);
    idle(2);
    cyc(0, 4'd0, 25'h0, 0, 1, 0);
    idle(10);

    // reset while draining discards the staged value
    wr(4'd1, 25'h000005);
    cyc(0, 4'd0, 25'h0, 1, 0, 0);
    cyc(0, 4'd0, 25'h0, 0, 1, 0);
    idle(3);
    cyc(0, 4'd0, 25'h0, 0, 0, 1);
    idle(12);
    cyc(0, 4'd0, 25'h0, 1, 0, 0);
    idle(2);
    check("s6_T12", 32'(t_out[1]), 32'h0);
    check("s6_T11", 32'(t_out[0]), 32'h001000);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rnd = $urandom;
      d = rnd[24:0];
      a = 4'($urandom_range(0, 15));
      if (a == 4'd9 && $urandom_range(0, 1) == 1) d = 25'($urandom_range(1, 640));
      if (a == 4'd10 && $urandom_range(0, 1) == 1) d = 25'($urandom_range(1, 480));
      cyc($urandom_range(0, 2) == 0, a, d,
          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 299) == 0);
    end
    idle(PIPE_DEPTH + 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
